// File: rtl/class_score_sequencer.sv
// rtl/class_score_sequencer.sv - output-layer class sequencer with running signed argmax
module class_score_sequencer #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 26,
    parameter int CLS_W     = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               img_valid,
    output logic               img_ready,
    output logic               mac_start,
    output logic [CLS_W-1:0]   mac_class,
    input  logic               mac_done,
    input  logic [SCORE_W-1:0] mac_score,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLS_W-1:0]   res_class,
    output logic [SCORE_W-1:0] res_score,
    output logic               res_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CLS_W-1:0]   idx_q, idx_d;
    logic [CLS_W-1:0]   best_idx_q, best_idx_d;
    logic [CLS_W-1:0]   res_class_q, res_class_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic [SCORE_W-1:0] res_score_q, res_score_d;
    logic               res_valid_q, res_valid_d;
    logic               res_err_q, res_err_d;
    logic               finish, abort, take;

    // Strict greater-than keeps the lowest index on ties; class 0 always seeds the argmax.
    assign take = (idx_q == '0) || ($signed(mac_score) > $signed(best_q));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        timer_d     = timer_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_score_d = res_score_q;
        res_err_d   = res_err_q;
        finish      = 1'b0;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (img_valid) begin
                    state_d   = S_ISSUE;
                    idx_d     = '0;
                    res_err_d = 1'b0;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mac_done) begin
                    if (take) begin
                        best_d     = mac_score;
                        best_idx_d = idx_q;
                    end
                    if (idx_q == CLS_W'(N_CLASSES - 1)) begin
                        finish = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The result is registered on DONE entry so it already includes the last class.
        if (finish) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
            res_err_d   = abort;
            res_class_d = abort ? CLS_W'(14) : best_idx_d;
            res_score_d = abort ? '0 : best_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_q      <= '0;
            timer_q     <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= CLS_W'(15);
            res_score_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_q      <= best_d;
            timer_q     <= timer_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_score_q <= res_score_d;
            res_err_q   <= res_err_d;
        end
    end

    assign img_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign mac_start = (state_q == S_ISSUE);
    assign mac_class = idx_q;
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_score = res_score_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_class_score_sequencer.sv
// tb/tb_class_score_sequencer.sv - table-driven bench for class_score_sequencer
module tb_class_score_sequencer;

    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 26;
    localparam int CLS_W     = 4;
    localparam int TIMEOUT   = 1023;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               img_valid = 1'b0;
    logic               img_ready;
    logic               mac_start;
    logic [CLS_W-1:0]   mac_class;
    logic               mac_done = 1'b0;
    logic [SCORE_W-1:0] mac_score = '0;
    logic               busy;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [CLS_W-1:0]   res_class;
    logic [SCORE_W-1:0] res_score;
    logic               res_err;

    int checks = 0;
    int failures = 0;

    class_score_sequencer #(
        .N_CLASSES(N_CLASSES), .SCORE_W(SCORE_W), .CLS_W(CLS_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .img_valid(img_valid), .img_ready(img_ready),
        .mac_start(mac_start), .mac_class(mac_class),
        .mac_done(mac_done), .mac_score(mac_score),
        .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score), .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0][25:0] sc;
        int               hold;
        bit               expiry;
        int               exp_cls;
        longint           exp_score;
        bit               exp_err;
        int               exp_starts;
        int               exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0][25:0] pack(input int a[10]);
        logic [9:0][25:0] r;
        for (int k = 0; k < 10; k++) r[k] = 26'(a[k]);
        return r;
    endfunction

    function automatic longint sres();
        return longint'($signed(res_score));
    endfunction

    // Launches one image and plays the MAC: answers each class in its first WAIT
    // cycle, except class v.hold, which is answered only on the expiry cycle (or never).
    task automatic run_image(input vec_t v, output int lat, output int starts, output int badcls);
        int t, waitcnt, cls;
        bit in_wait;
        t = 0; starts = 0; badcls = 0; waitcnt = 0; cls = 0; in_wait = 0;
        img_valid = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0;
        t = 1;
        while (!res_valid && t < 3000) begin
            mac_done = 1'b0;
            if (mac_start) begin
                if (int'(mac_class) != starts) badcls++;
                cls = int'(mac_class);
                starts++;
                in_wait = 1'b1;
                waitcnt = 0;
            end else if (in_wait) begin
                waitcnt++;
                if (cls != v.hold || (v.expiry && waitcnt == TIMEOUT)) begin
                    mac_done  = 1'b1;
                    mac_score = v.sc[cls];
                    in_wait   = 1'b0;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        mac_done = 1'b0;
        lat = t;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat, input int starts, input int badcls);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " res_valid"}, res_valid, 1);
        chk({tag, " res_class"}, res_class, v.exp_cls);
        chk({tag, " res_score"}, sres(), v.exp_score);
        chk({tag, " res_err"}, res_err, v.exp_err);
        chk({tag, " mac_start count"}, starts, v.exp_starts);
        chk({tag, " mac_class order errors"}, badcls, 0);
    endtask

    task automatic accept(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, " res_valid after accept"}, res_valid, 0);
        chk({tag, " img_ready after accept"}, img_ready, 1);
    endtask

    initial begin
        int s[10];
        int lat, starts, badcls;

        s = '{5, -3, 100, 7, 0, -50, 99, 1, 2, -1};
        vecs[0] = '{sc: pack(s), hold: -1, expiry: 0, exp_cls: 2, exp_score: 100, exp_err: 0, exp_starts: 10, exp_lat: 21};
        vecs[4] = '{sc: pack(s), hold: 5, expiry: 0, exp_cls: 14, exp_score: 0, exp_err: 1, exp_starts: 6, exp_lat: 12 + TIMEOUT};
        vecs[5] = '{sc: pack(s), hold: 5, expiry: 1, exp_cls: 2, exp_score: 100, exp_err: 0, exp_starts: 10, exp_lat: 21 + TIMEOUT - 1};
        s = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        vecs[1] = '{sc: pack(s), hold: -1, expiry: 0, exp_cls: 0, exp_score: 7, exp_err: 0, exp_starts: 10, exp_lat: 21};
        s = '{-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1};
        vecs[2] = '{sc: pack(s), hold: -1, expiry: 0, exp_cls: 9, exp_score: -1, exp_err: 0, exp_starts: 10, exp_lat: 21};
        s = '{0, 0, 0, 33554431, 0, 0, 0, -33554432, 0, 0};
        vecs[3] = '{sc: pack(s), hold: -1, expiry: 0, exp_cls: 3, exp_score: 33554431, exp_err: 0, exp_starts: 10, exp_lat: 21};

        repeat (3) @(posedge clk);
        #1;
        chk("reset res_class", res_class, 15);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_score", sres(), 0);
        chk("reset res_err", res_err, 0);
        chk("reset mac_start", mac_start, 0);
        chk("reset mac_class", mac_class, 0);
        chk("reset busy", busy, 0);
        chk("reset img_ready during rst", img_ready, 0);
        rst = 1'b0;
        #1;
        chk("img_ready after rst release", img_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_image(vecs[i], lat, starts, badcls);
            check_result($sformatf("vec%0d", i), vecs[i], lat, starts, badcls);
            accept($sformatf("vec%0d", i));
        end

        // Consumer stalls for 5 cycles, then a second image follows back-to-back.
        run_image(vecs[0], lat, starts, badcls);
        check_result("stall first", vecs[0], lat, starts, badcls);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall res_valid", res_valid, 1);
            chk("stall res_class", res_class, 2);
            chk("stall res_score", sres(), 100);
            chk("stall img_ready", img_ready, 0);
            chk("stall busy", busy, 1);
        end
        accept("stall");
        run_image(vecs[3], lat, starts, badcls);
        check_result("back-to-back", vecs[3], lat, starts, badcls);
        accept("back-to-back");

        // Reset while waiting on class 4; a late mac_done must be ignored.
        img_valid = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mac_done  = 1'b1;
            mac_score = 26'(k);
            @(posedge clk); #1;
            mac_done  = 1'b0;
        end
        chk("rst-mid mac_start class4", mac_start, 1);
        chk("rst-mid mac_class", mac_class, 4);
        @(posedge clk); #1;
        chk("rst-mid busy in wait", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst-mid res_class", res_class, 15);
        chk("rst-mid res_valid", res_valid, 0);
        chk("rst-mid mac_start", mac_start, 0);
        chk("rst-mid busy", busy, 0);
        rst       = 1'b0;
        mac_done  = 1'b1;
        mac_score = 26'd999;
        #1;
        chk("rst-mid img_ready after release", img_ready, 1);
        @(posedge clk); #1;
        mac_done = 1'b0;
        chk("late mac_done busy", busy, 0);
        chk("late mac_done res_valid", res_valid, 0);
        chk("late mac_done mac_start", mac_start, 0);
        chk("late mac_done res_class", res_class, 15);

        run_image(vecs[2], lat, starts, badcls);
        check_result("after reset", vecs[2], lat, starts, badcls);
        accept("after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
